// File: rtl/mfm_pkg.sv
// Shared types for the MFM decoder: FSM states, interval classes and the
// per-pulse emission record.
package mfm_pkg;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        PH_CLK  = 2'd1,
        PH_DATA = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        IVL_2T  = 2'd0,
        IVL_3T  = 2'd1,
        IVL_4T  = 2'd2,
        IVL_ERR = 2'd3
    } ivl_t;

    // Bits produced by one qualified pulse: none, one, or an ordered pair.
    typedef struct packed {
        logic vld;
        logic pair;
        logic first;
        logic second;
    } emit_t;

    function automatic emit_t mk_emit(input logic vld, input logic pair,
                                      input logic first, input logic second);
        emit_t e;
        e.vld    = vld;
        e.pair   = pair;
        e.first  = first;
        e.second = second;
        return e;
    endfunction

endpackage

// File: rtl/mfm_interval_classify.sv
// Combinational pulse-interval classifier. Compares twice the counter value
// against odd multiples of the half-cell so odd HALF_CELL_CLKS stay exact.
module mfm_interval_classify
    import mfm_pkg::*;
#(
    parameter int unsigned HALF_CELL_CLKS = 8,
    parameter int unsigned CNT_W          = 6
) (
    input  logic [CNT_W-1:0] i_cnt,
    output ivl_t             o_class_c
);

    localparam int unsigned W2    = CNT_W + 1;
    localparam int unsigned LIM_3 = 3 * HALF_CELL_CLKS;
    localparam int unsigned LIM_5 = 5 * HALF_CELL_CLKS;
    localparam int unsigned LIM_7 = 7 * HALF_CELL_CLKS;
    localparam int unsigned LIM_9 = 9 * HALF_CELL_CLKS;

    logic [W2-1:0] w_cnt2;

    assign w_cnt2 = {i_cnt, 1'b0};

    always_comb begin
        o_class_c = IVL_ERR;
        if (w_cnt2 < W2'(LIM_3)) begin
            o_class_c = IVL_ERR;
        end else if (w_cnt2 < W2'(LIM_5)) begin
            o_class_c = IVL_2T;
        end else if (w_cnt2 < W2'(LIM_7)) begin
            o_class_c = IVL_3T;
        end else if (w_cnt2 < W2'(LIM_9)) begin
            o_class_c = IVL_4T;
        end else begin
            o_class_c = IVL_ERR;
        end
    end

endmodule

// File: rtl/mfm_decode.sv
// MFM flux-pulse decoder: measures pulse spacing, tracks clock/data phase and
// emits data bits. Define MFM_DECODE_ERR_EN to add the decodeError pulse output.
module mfm_decode
    import mfm_pkg::*;
#(
    parameter int unsigned HALF_CELL_CLKS = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic mfmIn,
    input  logic mfmEdge,
    output logic currentRealBit,
    output logic currentRealBitValid
`ifdef MFM_DECODE_ERR_EN
    ,
    output logic decodeError
`endif
);

    localparam int unsigned CNT_SAT = 5 * HALF_CELL_CLKS;
    localparam int unsigned CNT_W   = $clog2(CNT_SAT + 1);
    localparam int unsigned LIM_TO  = 9 * HALF_CELL_CLKS;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic             w_pulse;
    logic             w_timeout;
    ivl_t             w_class;
    emit_t            w_emit;
    logic             r_bit;
    logic             r_vld;
    logic             r_pend_vld;
    logic             r_pend_bit;

    assign w_pulse   = mfmEdge & mfmIn;
    assign w_timeout = ({r_cnt, 1'b0} >= (CNT_W + 1)'(LIM_TO));

    mfm_interval_classify #(
        .HALF_CELL_CLKS (HALF_CELL_CLKS),
        .CNT_W          (CNT_W)
    ) u_classify (
        .i_cnt     (r_cnt),
        .o_class_c (w_class)
    );

    // Interval counter: cleared by a pulse, saturating otherwise.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (w_pulse) begin
            r_cnt <= '0;
        end else if (r_cnt != CNT_W'(CNT_SAT)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= HUNT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Phase tracking and bit emission for the current cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_emit      = '0;
        unique case (r_state)
            HUNT: begin
                if (w_pulse) begin
                    w_state_nxt = PH_CLK;
                end
            end
            PH_CLK: begin
                if (w_pulse) begin
                    unique case (w_class)
                        IVL_2T:  w_emit = mk_emit(1'b1, 1'b0, 1'b0, 1'b0);
                        IVL_3T: begin
                            w_emit      = mk_emit(1'b1, 1'b0, 1'b1, 1'b0);
                            w_state_nxt = PH_DATA;
                        end
                        default: w_state_nxt = PH_CLK;
                    endcase
                end else if (w_timeout) begin
                    w_state_nxt = HUNT;
                end
            end
            PH_DATA: begin
                if (w_pulse) begin
                    unique case (w_class)
                        IVL_2T:  w_emit = mk_emit(1'b1, 1'b0, 1'b1, 1'b0);
                        IVL_3T: begin
                            w_emit      = mk_emit(1'b1, 1'b1, 1'b0, 1'b0);
                            w_state_nxt = PH_CLK;
                        end
                        IVL_4T:  w_emit = mk_emit(1'b1, 1'b1, 1'b0, 1'b1);
                        default: w_state_nxt = PH_CLK;
                    endcase
                end else if (w_timeout) begin
                    w_state_nxt = HUNT;
                end
            end
            default: w_state_nxt = HUNT;
        endcase
    end

    // A pulse the cycle after a pair pulse classifies as ERR (interval 0), so a
    // pending second bit never competes with a new first bit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_bit      <= 1'b0;
            r_vld      <= 1'b0;
            r_pend_vld <= 1'b0;
            r_pend_bit <= 1'b0;
        end else if (r_pend_vld) begin
            r_bit      <= r_pend_bit;
            r_vld      <= 1'b1;
            r_pend_vld <= 1'b0;
        end else if (w_emit.vld) begin
            r_bit      <= w_emit.first;
            r_vld      <= 1'b1;
            r_pend_vld <= w_emit.pair;
            r_pend_bit <= w_emit.second;
        end else begin
            r_vld <= 1'b0;
        end
    end

    assign currentRealBit      = r_bit;
    assign currentRealBitValid = r_vld;

`ifdef MFM_DECODE_ERR_EN
    logic w_err;
    logic r_err;

    // Bad interval while locked (4T is illegal only from the clock phase) or timeout.
    assign w_err = (r_state != HUNT) &&
                   (w_pulse ? ((w_class == IVL_ERR) ||
                               ((r_state == PH_CLK) && (w_class == IVL_4T)))
                            : w_timeout);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_err;
        end
    end

    assign decodeError = r_err;
`endif

endmodule

// File: tb/tb_mfm_decode.sv
// Directed, table-driven bench for mfm_decode with HALF_CELL_CLKS = 8.
module tb_mfm_decode;

    localparam int unsigned H = 8;

    logic clk;
    logic rst;
    logic mfmIn;
    logic mfmEdge;
    logic currentRealBit;
    logic currentRealBitValid;
`ifdef MFM_DECODE_ERR_EN
    logic decodeError;
`endif

    mfm_decode #(.HALF_CELL_CLKS(H)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .mfmIn               (mfmIn),
        .mfmEdge             (mfmEdge),
        .currentRealBit      (currentRealBit),
        .currentRealBitValid (currentRealBitValid)
`ifdef MFM_DECODE_ERR_EN
        ,
        .decodeError         (decodeError)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int   gap;
        int   n;
        logic b0;
        logic b1;
        logic err;
    } vec_t;

    vec_t tbl[$];
    int   n_checks;
    int   n_fails;
    int   since;

    task automatic chk(input string name, input int idx,
                       input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s #%0d: got %0h, want %0h", name, idx, act, exp);
        end
    endtask

    // Drive one cycle, then sample just after the edge that consumed it.
    task automatic step(input logic e, input logic l);
        mfmEdge = e;
        mfmIn   = l;
        @(posedge clk);
        #1;
        mfmEdge = 1'b0;
        mfmIn   = 1'b0;
        since++;
    endtask

    // Idle until `gap` cycles after the previous pulse, pulse, check the two
    // cycles that follow.
    task automatic pulse_check(input int gap, input int n, input logic b0,
                               input logic b1, input logic err,
                               input string name, input int idx);
        int bad;
        int ebad;
        bad  = 0;
        ebad = 0;
        while (since < gap) begin
            step(1'b0, 1'b0);
            if (currentRealBitValid) bad++;
`ifdef MFM_DECODE_ERR_EN
            if (decodeError) ebad++;
`endif
        end
        chk({name, "_quiet"}, idx, 8'(bad), 8'd0);
`ifdef MFM_DECODE_ERR_EN
        chk({name, "_quiet_err"}, idx, 8'(ebad), 8'd0);
`endif
        since = 0;
        step(1'b1, 1'b1);
        chk({name, "_v0"}, idx, 8'(currentRealBitValid), 8'(n >= 1));
        if (n >= 1) chk({name, "_b0"}, idx, 8'(currentRealBit), 8'(b0));
`ifdef MFM_DECODE_ERR_EN
        chk({name, "_err"}, idx, 8'(decodeError), 8'(err));
`endif
        step(1'b0, 1'b0);
        chk({name, "_v1"}, idx, 8'(currentRealBitValid), 8'(n == 2));
        if (n == 2) chk({name, "_b1"}, idx, 8'(currentRealBit), 8'(b1));
    endtask

    function automatic void add(input int gap, input int n, input logic b0,
                                input logic b1, input logic err);
        vec_t v;
        v.gap = gap;
        v.n   = n;
        v.b0  = b0;
        v.b1  = b1;
        v.err = err;
        tbl.push_back(v);
    endfunction

    initial begin
        int bad;
        int ebad;
        n_checks = 0;
        n_fails  = 0;
        since    = 100;

        // Sync sequence after the preamble: 1,0,1,0,0,1,0,1,0,0,0.
        add(24, 1, 1'b1, 1'b0, 1'b0);
        add(32, 2, 1'b0, 1'b1, 1'b0);
        add(24, 2, 1'b0, 1'b0, 1'b0);
        add(24, 1, 1'b1, 1'b0, 1'b0);
        add(32, 2, 1'b0, 1'b1, 1'b0);
        add(24, 2, 1'b0, 1'b0, 1'b0);
        add(16, 1, 1'b0, 1'b0, 1'b0);
        // 4T from the clock phase is illegal; phase is kept.
        add(32, 0, 1'b0, 1'b0, 1'b1);
        add(16, 1, 1'b0, 1'b0, 1'b0);
        // Near class boundaries and error recovery in both phases.
        add(14, 1, 1'b0, 1'b0, 1'b0);
        add(19, 1, 1'b0, 1'b0, 1'b0);
        add(22, 1, 1'b1, 1'b0, 1'b0);
        add(14, 1, 1'b1, 1'b0, 1'b0);
        add(35, 2, 1'b0, 1'b1, 1'b0);
        add(11, 0, 1'b0, 1'b0, 1'b1);
        add(16, 1, 1'b0, 1'b0, 1'b0);
        add(11, 0, 1'b0, 1'b0, 1'b1);
        add(16, 1, 1'b0, 1'b0, 1'b0);
        add(22, 1, 1'b1, 1'b0, 1'b0);
        add(22, 2, 1'b0, 1'b0, 1'b0);
        add(16, 1, 1'b0, 1'b0, 1'b0);

        rst = 1'b0;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk("rst_bit", 0, 8'(currentRealBit), 8'd0);
        chk("rst_valid", 0, 8'(currentRealBitValid), 8'd0);
`ifdef MFM_DECODE_ERR_EN
        chk("rst_err", 0, 8'(decodeError), 8'd0);
`endif
        rst = 1'b1;

        pulse_check(0, 0, 1'b0, 1'b0, 1'b0, "hunt", 0);
        for (int i = 0; i < 45; i++) pulse_check(16, 1, 1'b0, 1'b0, 1'b0, "preamble", i);

        foreach (tbl[i]) pulse_check(tbl[i].gap, tbl[i].n, tbl[i].b0, tbl[i].b1,
                                     tbl[i].err, "table", i);

        // Edge without level and level without edge are not pulses.
        while (since < 6) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        pulse_check(16, 1, 1'b0, 1'b0, 1'b0, "qualify", 0);

        // Timeout in the clock phase drops back to HUNT.
        bad  = 0;
        ebad = 0;
        while (since < 50) begin
            step(1'b0, 1'b0);
            if (currentRealBitValid) bad++;
`ifdef MFM_DECODE_ERR_EN
            if (decodeError) ebad++;
`endif
        end
        chk("timeout_quiet", 0, 8'(bad), 8'd0);
`ifdef MFM_DECODE_ERR_EN
        chk("timeout_err_pulses", 0, 8'(ebad), 8'd1);
`endif
        pulse_check(0, 0, 1'b0, 1'b0, 1'b0, "timeout_hunt", 0);
        pulse_check(16, 1, 1'b0, 1'b0, 1'b0, "timeout_relock", 0);

        // Reset while the second bit of a 3T pair from PH_DATA is pending.
        pulse_check(24, 1, 1'b1, 1'b0, 1'b0, "to_data", 0);
        while (since < 24) step(1'b0, 1'b0);
        since = 0;
        step(1'b1, 1'b1);
        chk("pair_first_v", 0, 8'(currentRealBitValid), 8'd1);
        chk("pair_first_b", 0, 8'(currentRealBit), 8'd0);
        rst = 1'b0;
        step(1'b0, 1'b0);
        chk("pair_rst_v", 0, 8'(currentRealBitValid), 8'd0);
        rst = 1'b1;
        step(1'b0, 1'b0);
        chk("pair_after_v", 0, 8'(currentRealBitValid), 8'd0);
        pulse_check(16, 0, 1'b0, 1'b0, 1'b0, "rst_hunt", 0);
        pulse_check(16, 1, 1'b0, 1'b0, 1'b0, "rst_relock", 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/mfm_decode.md
MFM_DECODE -- requirements
Module: mfm_decode

Interface
REQ-001 Parameter HALF_CELL_CLKS, default 8, clk cycles per MFM half-cell (clock or data window); legal range 4..64.
REQ-002 Port clk  input  1  sole clock; all logic on rising edge.
REQ-003 Port rst  input  1  reset, synchronous, active-low (asserted when 0).
REQ-004 Port mfmIn  input  1  synchronized MFM level.
REQ-005 Port mfmEdge  input  1  one-cycle strobe marking an MFM flux pulse (rising edge of mfmIn).
REQ-006 Port currentRealBit  output  1  decoded data bit; meaningful only while currentRealBitValid=1.
REQ-007 Port currentRealBitValid  output  1  one-cycle strobe per decoded bit.

Function
REQ-008 A pulse SHALL be qualified only when mfmEdge=1 and mfmIn=1 in the same cycle; other cycles count as no pulse.
REQ-009 Interval counter SHALL clear to 0 in the cycle of a qualified pulse, increment by 1 each other cycle, saturate at 5*HALF_CELL_CLKS; the value held at the next pulse is the interval.
REQ-010 Classification, with H=HALF_CELL_CLKS: interval <3H/2 -> ERR; [3H/2,5H/2) -> 2T; [5H/2,7H/2) -> 3T; [7H/2,9H/2) -> 4T; >=9H/2 -> ERR.
REQ-011 States SHALL be HUNT, PH_CLK (last pulse in clock window) and PH_DATA (last pulse in data window).
REQ-012 HUNT + pulse -> PH_CLK, no bits emitted.
REQ-013 PH_CLK: 2T -> emit 0, stay PH_CLK; 3T -> emit 1, go PH_DATA; 4T or ERR -> emit nothing, decode error, stay PH_CLK with this pulse as reference.
REQ-014 PH_DATA: 2T -> emit 1, stay; 3T -> emit 0,0, go PH_CLK; 4T -> emit 0,1, stay PH_DATA; ERR -> emit nothing, decode error, go PH_CLK with this pulse as reference.
REQ-015 Counter reaching 9H/2 in PH_CLK or PH_DATA without a pulse SHALL trigger a decode error and a move to HUNT.
REQ-016 First emitted bit SHALL appear with currentRealBitValid=1 exactly 1 cycle after the pulse cycle; the second bit of a pair 2 cycles after it.
REQ-017 currentRealBitValid SHALL be 0 in all other cycles; currentRealBit holds its last value when not valid.
REQ-018 A pulse arriving while the second bit of a pair is pending SHALL NOT drop or reorder that bit; the minimum legal interval (3H/2 >= 6 cycles) makes this case unreachable.

Reset
REQ-019 While rst=0: state HUNT, counter 0, currentRealBit=0, currentRealBitValid=0, pending bit cleared, error output 0.
REQ-020 Reset asserted mid-pair SHALL discard the pending second bit.

Configuration
REQ-021 Macro MFM_DECODE_ERR_EN defined: add output decodeError (1 bit), a one-cycle pulse in the cycle after any decode error of REQ-013/014/015.
REQ-022 Macro MFM_DECODE_ERR_EN undefined: port decodeError absent; decoding behaviour otherwise identical.

Structure
REQ-023 Shared package mfm_pkg SHALL hold the state enumeration (HUNT, PH_CLK, PH_DATA) and the interval-class enumeration (2T, 3T, 4T, ERR).
REQ-024 Sub-module mfm_interval_classify SHALL implement REQ-010 combinationally from counter value and HALF_CELL_CLKS.

Verification
REQ-025 Reset: rst=0 for 2 cycles -> currentRealBit=0, currentRealBitValid=0, no decodeError.
REQ-026 Preamble: H=8; 46 pulses spaced 16 cycles -> 45 valid strobes, each with bit 0, each 1 cycle after its pulse; none for the first pulse.
REQ-027 Sync: after preamble, pulse gaps of 24,32,24,24,32,24,16 cycles -> bits 1,0,1,0,0,1,0,1,0,0,0 with no error.
REQ-028 Illegal 4T from PH_CLK: gap of 32 cycles after preamble -> no valid strobe, decodeError pulse; a following 16-cycle gap -> bit 0.
REQ-029 Timeout: no pulse for 36 cycles in PH_CLK -> decodeError, HUNT; next pulse emits nothing, the one after a 16-cycle gap emits 0.
REQ-030 Reset mid-pair: rst=0 in the cycle of the first bit of a 3T from PH_DATA -> second bit never appears, state HUNT.
